// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe
//  Purpose  : Registered WIDTH-bit bitwise logic unit (8 gate functions).
//             Results are held in a 2-entry in-order output queue with
//             valid/ready handshakes on both sides. The unit also provides
//             reduction flags for the head result and a wrapping count of
//             completed output handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_XOR  = 3'b010;
    localparam logic [2:0] c_OP_NOTA = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_XNOR = 3'b110;
    localparam logic [2:0] c_OP_PASS = 3'b111;

    // Queue occupancy; the encoding equals the number of held entries.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   head_q,  head_d;
    logic [WIDTH-1:0]   tail_q,  tail_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;

    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]   w_y;

    // Handshake qualifiers derive only from registered state, so in_ready
    // never depends combinationally on out_ready.
    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Bitwise gate function selected by op.
    always_comb begin
        w_result = '0;
        case (op)
            c_OP_AND:  w_result = a & b;
            c_OP_OR:   w_result = a | b;
            c_OP_XOR:  w_result = a ^ b;
            c_OP_NOTA: w_result = ~a;
            c_OP_NAND: w_result = ~(a & b);
            c_OP_NOR:  w_result = ~(a | b);
            c_OP_XNOR: w_result = ~(a ^ b);
            c_OP_PASS: w_result = a;
            default:   w_result = '0;
        endcase
    end

    // Queue next-state: head is the oldest entry; vacated slots are cleared
    // so an empty queue always presents zero.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        ops_done_d = w_pop ? (ops_done_q + CNT_W'(1)) : ops_done_q;
        case (state_q)
            S_EMPTY: begin
                if (w_push) begin
                    head_d  = w_result;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                case ({w_push, w_pop})
                    2'b10: begin
                        tail_d  = w_result;
                        state_d = S_FULL;
                    end
                    2'b01: begin
                        head_d  = '0;
                        state_d = S_EMPTY;
                    end
                    2'b11: begin
                        head_d  = w_result;
                    end
                    default: ;
                endcase
            end
            S_FULL: begin
                if (w_pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = S_ONE;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                state_d = S_EMPTY;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ops_done_q <= ops_done_d;
        end
    end

    // Head presentation and reductions, forced to zero when the queue is empty.
    always_comb begin
        w_y     = out_valid ? head_q : '0;
        y       = w_y;
        red_and = out_valid & (&w_y);
        red_or  = |w_y;
        red_xor = ^w_y;
    end

    assign ops_done = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_pipe
//  Purpose  : Scoreboard bench for logic_unit_pipe: directed scenarios plus
//             randomized traffic against a truth-table reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             red_and;
    logic             red_or;
    logic             red_xor;
    logic [CNT_W-1:0] ops_done;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] sb[$];
    int               push_pending = 0;
    int               model_ops = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .red_and   (red_and),
        .red_or    (red_or),
        .red_xor   (red_xor),
        .ops_done  (ops_done)
    );

    // Reference: each opcode is a 2-input truth table indexed by {a_bit,b_bit}.
    function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] aa,
                                                  input logic [WIDTH-1:0] bb);
        logic [3:0]       tt [8];
        logic [3:0]       row;
        logic [WIDTH-1:0] r;
        tt[0] = 4'b1000;  // AND
        tt[1] = 4'b1110;  // OR
        tt[2] = 4'b0110;  // XOR
        tt[3] = 4'b0011;  // NOT a
        tt[4] = 4'b0111;  // NAND
        tt[5] = 4'b0001;  // NOR
        tt[6] = 4'b1001;  // XNOR
        tt[7] = 4'b1100;  // PASS a
        row = tt[o];
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = row[{aa[i], bb[i]}];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied just after a rising edge. An accept is
    // known now because in_ready cannot change before the next edge.
    task automatic step(input logic v, input logic [2:0] o,
                        input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input logic ordy);
        in_valid  = v;
        op        = o;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        push_pending = (rst_n && v && in_ready) ? 1 : 0;
        if (push_pending != 0) sb.push_back(ref_gate(o, aa, bb));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin : mon
        int               exp_cnt;
        logic [WIDTH-1:0] h;
        int               ones;
        if (!rst_n) begin
            sb.delete();
            model_ops = 0;
        end else begin
            exp_cnt = sb.size() - push_pending;
            h       = (exp_cnt != 0) ? sb[0] : '0;
            ones    = $countones(h);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_cnt != 0});
            chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_cnt < 2});
            chk("ops_done",  32'(ops_done),      32'(model_ops % (1 << CNT_W)));
            chk("y",         32'(y),             32'(h));
            chk("red_and",   {31'd0, red_and},   {31'd0, (exp_cnt != 0) && (ones == WIDTH)});
            chk("red_or",    {31'd0, red_or},    {31'd0, ones > 0});
            chk("red_xor",   {31'd0, red_xor},   {31'd0, (ones % 2) == 1});
            if (exp_cnt != 0 && out_ready) begin
                void'(sb.pop_front());
                model_ops++;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 3'd0, 8'h00, 8'h00, 0);

        // All eight functions on F0/3C, consumer always ready.
        for (int o = 0; o < 8; o++) step(1, 3'(o), 8'hF0, 8'h3C, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1);

        // CC/AA pairs every {a,b} bit combination: full truth tables.
        for (int o = 0; o < 8; o++) step(1, 3'(o), 8'hCC, 8'hAA, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1);

        // Backpressure: third accept stalls, then drain in order.
        step(1, 3'd7, 8'h01, 8'h00, 0);
        step(1, 3'd7, 8'h02, 8'h00, 0);
        step(1, 3'd7, 8'h03, 8'h00, 0);
        step(1, 3'd7, 8'h03, 8'h00, 0);
        step(1, 3'd7, 8'h03, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1);

        // Single entry with simultaneous push and pop.
        step(1, 3'd7, 8'h0A, 8'h00, 0);
        step(1, 3'd7, 8'h0B, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 0);
        step(0, 3'd0, 8'h00, 8'h00, 1);

        // Reduction corner values.
        step(1, 3'd7, 8'hFF, 8'h00, 0);
        step(1, 3'd7, 8'h01, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1);

        // Counter wrap, then reset while the queue is full.
        for (int i = 0; i < 9; i++) step(1, 3'd7, 8'(i), 8'h00, 1);
        step(1, 3'd7, 8'h11, 8'h00, 0);
        step(1, 3'd7, 8'h22, 8'h00, 0);
        step(0, 3'd0, 8'h00, 8'h00, 0);
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        push_pending = 0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 3'd0, 8'h00, 8'h00, 0);
        step(1, 3'd0, 8'hF0, 8'h3C, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 6));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            step(0, 3'd0, 8'h00, 8'h00, 1);
        end
        step(0, 3'd0, 8'h00, 8'h00, 1);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
